// File: rtl/rtc_pkg.sv
// Shared RTC load-controller types: opcodes, response codes, FSM states and field widths.
package rtc_pkg;

   localparam int SEC_W = 48;
   localparam int NS_W  = 38;
   localparam int PER_W = 40;
   localparam int ADJ_W = 32;

   localparam logic [29:0] NS_PER_SEC = 30'd1_000_000_000;

   typedef enum logic [1:0] {
      OP_TIME_LD   = 2'd0,
      OP_PERIOD_LD = 2'd1,
      OP_ADJ_LD    = 2'd2,
      OP_TIME_RD   = 2'd3
   } rtc_op_e;

   typedef enum logic [1:0] {
      RSP_OK      = 2'd0,
      RSP_BAD_ARG = 2'd1,
      RSP_TIMEOUT = 2'd2
   } rtc_rsp_e;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_LOAD     = 2'd1,
      ST_WAIT_ADJ = 2'd2,
      ST_RESP     = 2'd3
   } ld_state_e;

   // ns field carries whole nanoseconds in [37:8]; the low byte is a sub-ns fraction.
   function automatic logic arg_bad(input rtc_op_e op, input logic [NS_W-1:0] ns,
                                    input logic [PER_W-1:0] per, input logic [ADJ_W-1:0] cnt);
      case (op)
         OP_TIME_LD:   arg_bad = (ns[NS_W-1:8] >= NS_PER_SEC);
         OP_PERIOD_LD: arg_bad = (per == {PER_W{1'b0}});
         OP_ADJ_LD:    arg_bad = (cnt == {ADJ_W{1'b0}});
         default:      arg_bad = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/rtc_ld_ctrl.sv
// Command front-end that validates load requests, strobes load data into the RTC,
// waits (bounded) for adjustment completion and returns one response per command.
module rtc_ld_ctrl
   import rtc_pkg::*;
#(
   parameter logic [31:0] ADJ_TO_CYCLES = 32'd1048576
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [SEC_W-1:0] cmd_sec,
   input  logic [NS_W-1:0]  cmd_ns,
   input  logic [PER_W-1:0] cmd_period,
   input  logic [ADJ_W-1:0] cmd_adj_cnt,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [1:0]       rsp_code,
   output logic [SEC_W-1:0] rsp_sec,
   output logic [NS_W-1:0]  rsp_ns,
   output logic             time_ld,
   output logic             period_ld,
   output logic             adj_ld,
   output logic [SEC_W-1:0] time_reg_sec_in,
   output logic [NS_W-1:0]  time_reg_ns_in,
   output logic [PER_W-1:0] period_in,
   output logic [PER_W-1:0] period_adj,
   output logic [ADJ_W-1:0] adj_ld_data,
   input  logic             adj_ld_done,
   input  logic [SEC_W-1:0] time_reg_sec,
   input  logic [NS_W-1:0]  time_reg_ns
);

   ld_state_e        state_q, state_d;
   rtc_op_e          op_q, op_d;
   logic             time_ld_q, time_ld_d;
   logic             period_ld_q, period_ld_d;
   logic             adj_ld_q, adj_ld_d;
   logic [SEC_W-1:0] sec_in_q, sec_in_d;
   logic [NS_W-1:0]  ns_in_q, ns_in_d;
   logic [PER_W-1:0] period_in_q, period_in_d;
   logic [PER_W-1:0] period_adj_q, period_adj_d;
   logic [ADJ_W-1:0] adj_data_q, adj_data_d;
   logic             rsp_valid_q, rsp_valid_d;
   rtc_rsp_e         rsp_code_q, rsp_code_d;
   logic [SEC_W-1:0] rsp_sec_q, rsp_sec_d;
   logic [NS_W-1:0]  rsp_ns_q, rsp_ns_d;
   logic [31:0]      to_cnt_q, to_cnt_d;
   logic             done_prev_q, done_prev_d;
   rtc_op_e          cmd_op_s;
   logic             done_rise_s;

   assign cmd_op_s    = rtc_op_e'(cmd_op);
   // Prior-cycle sampling means a level already high at the strobe never counts as a rise.
   assign done_rise_s = adj_ld_done & ~done_prev_q;

   // Next-state, load-register and response computation.
   always_comb begin
      state_d      = state_q;
      op_d         = op_q;
      time_ld_d    = 1'b0;
      period_ld_d  = 1'b0;
      adj_ld_d     = 1'b0;
      sec_in_d     = sec_in_q;
      ns_in_d      = ns_in_q;
      period_in_d  = period_in_q;
      period_adj_d = period_adj_q;
      adj_data_d   = adj_data_q;
      rsp_code_d   = rsp_code_q;
      rsp_sec_d    = rsp_sec_q;
      rsp_ns_d     = rsp_ns_q;
      to_cnt_d     = to_cnt_q;
      done_prev_d  = adj_ld_done;
      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               op_d = cmd_op_s;
               if (arg_bad(cmd_op_s, cmd_ns, cmd_period, cmd_adj_cnt)) begin
                  state_d    = ST_RESP;
                  rsp_code_d = RSP_BAD_ARG;
               end else if (cmd_op_s == OP_TIME_RD) begin
                  state_d    = ST_RESP;
                  rsp_code_d = RSP_OK;
                  rsp_sec_d  = time_reg_sec;
                  rsp_ns_d   = time_reg_ns;
               end else begin
                  state_d    = ST_LOAD;
                  rsp_code_d = RSP_OK;
                  case (cmd_op_s)
                     OP_TIME_LD: begin
                        time_ld_d = 1'b1;
                        sec_in_d  = cmd_sec;
                        ns_in_d   = cmd_ns;
                     end
                     OP_PERIOD_LD: begin
                        period_ld_d = 1'b1;
                        period_in_d = cmd_period;
                     end
                     OP_ADJ_LD: begin
                        adj_ld_d     = 1'b1;
                        period_adj_d = cmd_period;
                        adj_data_d   = cmd_adj_cnt;
                     end
                     default: state_d = ST_RESP;
                  endcase
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_LOAD: begin
            if (op_q == OP_ADJ_LD) begin
               state_d  = ST_WAIT_ADJ;
               to_cnt_d = 32'd0;
            end else begin
               state_d = ST_RESP;
            end
         end
         ST_WAIT_ADJ: begin
            if (done_rise_s) begin
               state_d    = ST_RESP;
               rsp_code_d = RSP_OK;
            end else if ((to_cnt_q + 32'd1) == ADJ_TO_CYCLES) begin
               state_d    = ST_RESP;
               rsp_code_d = RSP_TIMEOUT;
            end else begin
               to_cnt_d = to_cnt_q + 32'd1;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_RESP;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      rsp_valid_d = (state_d == ST_RESP);
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         op_q         <= OP_TIME_LD;
         time_ld_q    <= 1'b0;
         period_ld_q  <= 1'b0;
         adj_ld_q     <= 1'b0;
         sec_in_q     <= {SEC_W{1'b0}};
         ns_in_q      <= {NS_W{1'b0}};
         period_in_q  <= {PER_W{1'b0}};
         period_adj_q <= {PER_W{1'b0}};
         adj_data_q   <= {ADJ_W{1'b0}};
         rsp_valid_q  <= 1'b0;
         rsp_code_q   <= RSP_OK;
         rsp_sec_q    <= {SEC_W{1'b0}};
         rsp_ns_q     <= {NS_W{1'b0}};
         to_cnt_q     <= 32'd0;
         done_prev_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         op_q         <= op_d;
         time_ld_q    <= time_ld_d;
         period_ld_q  <= period_ld_d;
         adj_ld_q     <= adj_ld_d;
         sec_in_q     <= sec_in_d;
         ns_in_q      <= ns_in_d;
         period_in_q  <= period_in_d;
         period_adj_q <= period_adj_d;
         adj_data_q   <= adj_data_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_code_q   <= rsp_code_d;
         rsp_sec_q    <= rsp_sec_d;
         rsp_ns_q     <= rsp_ns_d;
         to_cnt_q     <= to_cnt_d;
         done_prev_q  <= done_prev_d;
      end
   end

   assign cmd_ready       = (state_q == ST_IDLE);
   assign rsp_valid       = rsp_valid_q;
   assign rsp_code        = rsp_code_q;
   assign rsp_sec         = rsp_sec_q;
   assign rsp_ns          = rsp_ns_q;
   assign time_ld         = time_ld_q;
   assign period_ld       = period_ld_q;
   assign adj_ld          = adj_ld_q;
   assign time_reg_sec_in = sec_in_q;
   assign time_reg_ns_in  = ns_in_q;
   assign period_in       = period_in_q;
   assign period_adj      = period_adj_q;
   assign adj_ld_data     = adj_data_q;

endmodule
